dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-master arbiter sharing one single-port, word-wide data memory between the RV32I core's load/store port (m0) and a program-loader/debug port (m1). It sits between the core's data-memory request signals and the memory macro. It grants at most one request per cycle, using round-robin or fixed priority. Every accepted request gets a one-cycle-later response, with address checking for alignment and range.

## Interface
Parameters:
- DEPTH_WORDS, 1024: memory depth in 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- AW, $clog2(DEPTH_WORDS): memory word-address width.

Ports (clock and reset first):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mX_req  in  1  request valid, for X = 0, 1.
- mX_we  in  1  1 = write, 0 = read.
- mX_addr  in  32  byte address.
- mX_wdata  in  32  store data.
- mX_gnt  out  1  request accepted this cycle; combinational.
- mX_rvalid  out  1  response for the accepted request; registered.
- mX_rdata  out  32  read data, qualified by mX_rvalid.
- mX_err  out  1  response error flag, qualified by mX_rvalid.
- mem_en  out  1  memory access enable; combinational.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  word address, equal to the winner's mX_addr[AW+1:2].
- mem_wdata  out  32  write data.
- mem_rdata  in  32  synchronous read data, valid the cycle after mem_en with mem_we = 0.

## Operation
- **Request rule:** a master holds req/we/addr/wdata stable until it sees gnt; it may drop req only after gnt.
- **Address check:** a request is illegal if addr[1:0] != 0 or addr >= 4*DEPTH_WORDS.
- **Arbitration:** evaluated every cycle over the active requests.
  - With one requester, that requester wins.
  - With both requesting, the master not granted most recently wins.
  - The last-grant pointer updates only on a grant and resets to 1, so m0 wins the first tie.
- **Legal winner:**
  - gnt = 1 and mem_en = 1.
  - mem_we, mem_addr and mem_wdata are driven from the winner.
- **Illegal winner:**
  - gnt = 1 and mem_en = 0; memory is untouched.
  - The response carries err = 1.
- **Idle:** with no request, mem_en = 0 and mem_we = 0. mem_addr and mem_wdata are driven from m0 fields; their values are don't-care.
- **Response register:** holds {valid, owner, is_read, err}.
  - Loaded every cycle from the current grant, or cleared when there is no grant.
  - This is the only state besides the last-grant pointer. There is no FSM beyond the two-state pointer.
- **Response outputs:** mX_rvalid = valid & (owner == X).
  - mX_rdata = mem_rdata when valid, owner == X, is_read and !err; otherwise 0.
  - Writes also get an rvalid acknowledge, with rdata = 0.
- **Throughput:** one request per cycle total, so back-to-back grants are allowed. A master waiting against a continuously requesting peer is granted within 2 cycles.

## Timing
- **Request to response:** a request granted in cycle T drives the memory in T. mX_rvalid, mX_err and mX_rdata are valid in T+1 for exactly one cycle.
- **Grant path:** gnt and mem_* are combinational from req/addr and the pointer, with no added cycle. The core therefore sees a one-cycle load response.
- **Simultaneous events:** a new grant in T+1 and the response for T coexist. The responses may go to different masters in consecutive cycles.
- **Reset values:** pointer = 1, response valid = 0.
  - Hence all mX_rvalid = 0, mX_rdata = 0, mX_err = 0.
  - mem_en and mem_we follow requests combinationally; they are 0 when no requests are active.
- **Reset mid-operation:** asserting rst in T+1 drops the pending response with no rvalid. A write granted in T before reset has already reached memory and stands.
- **Address range:** address 4*DEPTH_WORDS-4 is legal; 4*DEPTH_WORDS is illegal. There is no address wrap.

## Configuration
- ARB_FIXED_PRIO_EN defined: m0 always wins ties and the last-grant pointer is not implemented. m1 can starve while m0 requests every cycle.
- ARB_FIXED_PRIO_EN undefined (default): round-robin as described in Operation.

## Test plan
- Reset, then m0 writes 0xDEADBEEF to 0x10 and then reads 0x10:
  - gnt in the same cycle for each request.
  - rvalid T+1 for each.
  - Read rdata = 0xDEADBEEF, err = 0.
- Both masters request every cycle for 6 cycles:
  - Grants alternate m0, m1, m0, m1, m0, m1 (round-robin).
  - With ARB_FIXED_PRIO_EN, m0 is granted all 6 and m1 gets no grant.
- m1 reads 0x2 (misaligned) and 0x1000 with DEPTH_WORDS = 1024:
  - gnt = 1 and mem_en = 0 for each.
  - m1_rvalid = 1, m1_err = 1, m1_rdata = 0 in the following cycle.
- Back-to-back requests, m0 reads 0x0 in cycle T and m1 reads 0x4 in T+1 (memory preloaded 0x11, 0x22):
  - m0_rvalid and rdata = 0x11 in T+1.
  - m1_rvalid and rdata = 0x22 in T+2.
  - No overlap on rvalid.
- Reset mid-operation, with rst asserted in the cycle after an m0 read grant:
  - No m0_rvalid.
  - After release, the first tie goes to m0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter in front of one single-port word-wide data memory.
// m0 is the core load/store port, m1 the loader/debug port. One grant per cycle,
// and every granted request gets a response one cycle later with an alignment and range check.
// Optional build macro: ARB_FIXED_PRIO_EN. When it is defined, m0 always wins ties
// and there is no last-grant pointer. When it is undefined, ties go round-robin.
module dmem_arbiter #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [31:0]   m0_addr,
   input  logic [31:0]   m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [31:0]   m0_rdata,
   output logic          m0_err,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [31:0]   m1_addr,
   input  logic [31:0]   m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [31:0]   m1_rdata,
   output logic          m1_err,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   // The limit is 33 bits wide so that 4*DEPTH_WORDS never wraps against a 32-bit address.
   localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

   logic any_req;
   logic sel_m1;
   logic legal0, legal1;
   logic win_legal, win_we;

   logic rsp_valid, rsp_owner, rsp_read, rsp_err;

   assign any_req = m0_req | m1_req;
   assign legal0  = (m0_addr[1:0] == 2'b00) && ({1'b0, m0_addr} < ADDR_LIMIT);
   assign legal1  = (m1_addr[1:0] == 2'b00) && ({1'b0, m1_addr} < ADDR_LIMIT);

`ifdef ARB_FIXED_PRIO_EN
   // m1 wins only when m0 is idle.
   assign sel_m1 = m1_req & ~m0_req;
`else
   // Last-grant pointer states:
   //   state   | meaning
   //   LAST_M0 | m0 was granted most recently; m1 wins the next tie
   //   LAST_M1 | m1 was granted most recently (reset); m0 wins the next tie
   typedef enum logic {LAST_M0 = 1'b0, LAST_M1 = 1'b1} last_t;
   last_t last_q, last_d;

   // Pointer register; it resets to LAST_M1 so that m0 wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_q <= LAST_M1;
      else     last_q <= last_d;
   end

   // Pick the winner and move the pointer only when something is granted.
   always_comb begin
      last_d = last_q;
      sel_m1 = 1'b0;
      if (m0_req && m1_req) sel_m1 = (last_q == LAST_M0);
      else                  sel_m1 = m1_req;
      if (any_req) last_d = sel_m1 ? LAST_M1 : LAST_M0;
   end
`endif

   assign m0_gnt    = any_req & ~sel_m1;
   assign m1_gnt    = sel_m1;
   assign win_legal = sel_m1 ? legal1 : legal0;
   assign win_we    = sel_m1 ? m1_we  : m0_we;

   // With no request the mux falls through to m0's fields. Those values are don't-care while mem_en = 0.
   assign mem_en    = any_req & win_legal;
   assign mem_we    = mem_en & win_we;
   assign mem_addr  = sel_m1 ? m1_addr[AW+1:2] : m0_addr[AW+1:2];
   assign mem_wdata = sel_m1 ? m1_wdata : m0_wdata;

   // Response register: capture this cycle's grant, or clear it when nothing is granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_owner <= 1'b0;
         rsp_read  <= 1'b0;
         rsp_err   <= 1'b0;
      end else if (any_req) begin
         rsp_valid <= 1'b1;
         rsp_owner <= sel_m1;
         rsp_read  <= ~win_we;
         rsp_err   <= ~win_legal;
      end else begin
         rsp_valid <= 1'b0;
         rsp_owner <= 1'b0;
         rsp_read  <= 1'b0;
         rsp_err   <= 1'b0;
      end
   end

   assign m0_rvalid = rsp_valid & ~rsp_owner;
   assign m1_rvalid = rsp_valid &  rsp_owner;
   assign m0_err    = m0_rvalid & rsp_err;
   assign m1_err    = m1_rvalid & rsp_err;
   assign m0_rdata  = (m0_rvalid & rsp_read & ~rsp_err) ? mem_rdata : 32'h0;
   assign m1_rdata  = (m1_rvalid & rsp_read & ~rsp_err) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter. It contains a behavioural synchronous memory.
// Inputs change 1 ns after the rising edge. Combinational outputs are checked after that,
// and registered outputs are checked 1 ns after the next edge.
module tb_dmem_arbiter;

   localparam int DEPTH = 1024;
   localparam int AW    = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_we, m1_req, m1_we;
   logic [31:0]   m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic          m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
   logic [31:0]   m0_rdata, m1_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata, mem_rdata;

   logic [31:0]   mem [0:DEPTH-1];

   int tests = 0;
   int fails = 0;

   dmem_arbiter #(.DEPTH_WORDS(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous single-port memory model.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle();
      tick();
      tick();
      tests++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin fails++; $display("FAIL reset_rvalid got %b exp 00", {m0_rvalid, m1_rvalid}); end
      tests++; if ({m0_err, m1_err} !== 2'b00) begin fails++; $display("FAIL reset_err got %b exp 00", {m0_err, m1_err}); end
      tests++; if ({m0_rdata, m1_rdata} !== 64'h0) begin fails++; $display("FAIL reset_rdata got %h exp 0", {m0_rdata, m1_rdata}); end
      tests++; if ({mem_en, mem_we} !== 2'b00) begin fails++; $display("FAIL reset_mem_en_we got %b exp 00", {mem_en, mem_we}); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_write_read;
      m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF;
      #1;
      tests++; if ({m0_gnt, m1_gnt, mem_en, mem_we} !== 4'b1011) begin fails++; $display("FAIL wr_gnt got %b exp 1011", {m0_gnt, m1_gnt, mem_en, mem_we}); end
      tests++; if (mem_addr !== 10'd4 || mem_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_mem got addr %0d data %h exp 4 deadbeef", mem_addr, mem_wdata); end
      tick();
      m0_we = 0; m0_wdata = 0;
      tests++; if ({m0_rvalid, m1_rvalid, m0_err} !== 3'b100 || m0_rdata !== 32'h0) begin fails++; $display("FAIL wr_ack got %b rdata %h exp 100 0", {m0_rvalid, m1_rvalid, m0_err}, m0_rdata); end
      #1;
      tests++; if ({m0_gnt, mem_en, mem_we} !== 3'b110) begin fails++; $display("FAIL rd_gnt got %b exp 110", {m0_gnt, mem_en, mem_we}); end
      tick();
      idle();
      tests++; if ({m0_rvalid, m0_err} !== 2'b10 || m0_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_resp got %b rdata %h exp 10 deadbeef", {m0_rvalid, m0_err}, m0_rdata); end
      tick();
      tests++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin fails++; $display("FAIL rd_one_cycle got %b exp 00", {m0_rvalid, m1_rvalid}); end
   endtask

   task automatic test_back_to_back;
      m1_req = 1; m1_we = 1; m1_addr = 32'h0; m1_wdata = 32'h11;
      tick();
      m1_addr = 32'h4; m1_wdata = 32'h22;
      tick();
      idle();
      m0_req = 1; m0_addr = 32'h0;
      #1;
      tests++; if ({m0_gnt, m1_gnt} !== 2'b10) begin fails++; $display("FAIL b2b_gnt0 got %b exp 10", {m0_gnt, m1_gnt}); end
      tick();
      idle();
      m1_req = 1; m1_addr = 32'h4;
      tests++; if ({m0_rvalid, m1_rvalid} !== 2'b10 || m0_rdata !== 32'h11) begin fails++; $display("FAIL b2b_t1 got %b rdata %h exp 10 11", {m0_rvalid, m1_rvalid}, m0_rdata); end
      #1;
      tests++; if ({m0_gnt, m1_gnt} !== 2'b01) begin fails++; $display("FAIL b2b_gnt1 got %b exp 01", {m0_gnt, m1_gnt}); end
      tick();
      idle();
      tests++; if ({m0_rvalid, m1_rvalid} !== 2'b01 || m1_rdata !== 32'h22) begin fails++; $display("FAIL b2b_t2 got %b rdata %h exp 01 22", {m0_rvalid, m1_rvalid}, m1_rdata); end
      tick();
   endtask

   task automatic test_illegal;
      logic [31:0] addrs [3];
      logic        errs  [3];
      addrs[0] = 32'h2;   errs[0] = 1'b1;
      addrs[1] = 32'h1000; errs[1] = 1'b1;
      addrs[2] = 32'hFFC; errs[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         idle();
         m1_req = 1; m1_addr = addrs[i];
         #1;
         tests++; if ({m1_gnt, mem_en} !== {1'b1, ~errs[i]}) begin fails++; $display("FAIL illegal_gnt[%0d] got %b exp %b", i, {m1_gnt, mem_en}, {1'b1, ~errs[i]}); end
         tick();
         idle();
         tests++; if ({m0_rvalid, m1_rvalid, m1_err} !== {2'b01, errs[i]}) begin fails++; $display("FAIL illegal_resp[%0d] got %b exp %b", i, {m0_rvalid, m1_rvalid, m1_err}, {2'b01, errs[i]}); end
         if (errs[i]) begin
            tests++; if (m1_rdata !== 32'h0) begin fails++; $display("FAIL illegal_rdata[%0d] got %h exp 0", i, m1_rdata); end
         end
      end
      tick();
   endtask

   task automatic test_round_robin;
      logic prev_m1;
      logic exp_m1;
      m0_req = 1; m0_addr = 32'h0;
      m1_req = 1; m1_addr = 32'h4;
      for (int i = 0; i < 6; i++) begin
`ifdef ARB_FIXED_PRIO_EN
         exp_m1 = 1'b0;
`else
         exp_m1 = (i % 2) == 1;
`endif
         #1;
         tests++; if ({m0_gnt, m1_gnt} !== {~exp_m1, exp_m1}) begin fails++; $display("FAIL rr_gnt[%0d] got %b exp %b", i, {m0_gnt, m1_gnt}, {~exp_m1, exp_m1}); end
         prev_m1 = exp_m1;
         tick();
         tests++; if ({m0_rvalid, m1_rvalid} !== {~prev_m1, prev_m1} || (prev_m1 ? m1_rdata : m0_rdata) !== (prev_m1 ? 32'h22 : 32'h11)) begin
            fails++; $display("FAIL rr_resp[%0d] got %b rdata %h/%h", i, {m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata);
         end
      end
      idle();
      tick();
   endtask

   task automatic test_reset_mid;
      // Pointer ends on m0 after this read, so without the reset a tie would go to m1.
      m0_req = 1; m0_addr = 32'h10;
      #1;
      tests++; if (m0_gnt !== 1'b1) begin fails++; $display("FAIL rstmid_gnt got %b exp 1", m0_gnt); end
      @(negedge clk);
      rst = 1'b1;
      idle();
      tick();
      tests++; if (m0_rvalid !== 1'b0) begin fails++; $display("FAIL rstmid_rvalid got %b exp 0", m0_rvalid); end
      tick();
      rst = 1'b0;
      tests++; if (m0_rvalid !== 1'b0) begin fails++; $display("FAIL rstmid_rvalid2 got %b exp 0", m0_rvalid); end
      m0_req = 1; m0_addr = 32'h0;
      m1_req = 1; m1_addr = 32'h4;
      #1;
      tests++; if ({m0_gnt, m1_gnt} !== 2'b10) begin fails++; $display("FAIL rstmid_tie got %b exp 10", {m0_gnt, m1_gnt}); end
      tick();
      idle();
      tests++; if (mem[4] !== 32'hDEADBEEF) begin fails++; $display("FAIL rstmid_mem got %h exp deadbeef", mem[4]); end
      tick();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_back_to_back();
      test_illegal();
      test_round_robin();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
